// File: rtl/diferential_muxpga_pkg.sv
// Shared types and constants for the diferential_muxpga configuration path.
package diferential_muxpga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    FRST,
    RUN,
    ERR
  } state_e;

  localparam int CELL_CFG_BITS = 8;

  // Field offsets within one cell's configuration byte.
  localparam int MUX1_LSB = 0;
  localparam int MUX2_LSB = 2;
  localparam int FN_LSB   = 4;

  function automatic int nib_count(input int cells, input int cfg_bits);
    return (cells * cfg_bits) / 4;
  endfunction

endpackage

// File: rtl/diferential_cfg_bank.sv
// Shadow nibble bank plus active configuration register loaded on commit.
module diferential_cfg_bank #(
  parameter int N  = 18,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic [CW-1:0]   wr_idx_i,
  input  logic [3:0]      wr_nib_i,
  input  logic            commit_i,
  output logic [N*4-1:0]  active_o
);

  logic [N-1:0][3:0] shadow_q;
  logic [N*4-1:0]    active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en_i) shadow_q[wr_idx_i] <= wr_nib_i;
      if (commit_i) active_q <= shadow_q;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/diferential_cfg_loader.sv
// Nibble-serial configuration loader with XOR checksum, atomic commit and fabric reset sequencing.
// Optional readback stream enabled by DIFERENTIAL_CFG_READBACK_EN.
module diferential_cfg_loader
  import diferential_muxpga_pkg::*;
#(
  parameter int CELLS      = 9,
  parameter int CFG_BITS   = CELL_CFG_BITS,
  parameter int RST_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_valid,
  input  logic [3:0]                cfg_nib,
  output logic [CELLS*CFG_BITS-1:0] cell_cfg,
  output logic                      fabric_en,
  output logic                      fabric_rst,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef DIFERENTIAL_CFG_READBACK_EN
  ,
  input  logic                      rb_req,
  output logic                      rb_valid,
  output logic [3:0]                rb_nib
`endif
);

  localparam int N   = nib_count(CELLS, CFG_BITS);
  localparam int CW  = $clog2(N);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(N - 1);
  localparam logic [RCW-1:0] HOLD_INIT = RCW'(RST_CYCLES - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     csum_q, csum_d;
  logic [RCW-1:0] hold_q, hold_d;
  logic           cfg_ok_q, cfg_ok_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           wr_en, commit, start_ok, rb_busy;

  diferential_cfg_bank #(.N(N), .CW(CW)) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .wr_idx_i (cnt_q),
    .wr_nib_i (cfg_nib),
    .commit_i (commit),
    .active_o (cell_cfg)
  );

`ifdef DIFERENTIAL_CFG_READBACK_EN
  localparam int RBW = $clog2(N + 1);
  localparam logic [RBW-1:0] RB_LAST = RBW'(N);

  logic [N-1:0][3:0] act_nibs;
  logic              rb_act_q, rb_act_d;
  logic [RBW-1:0]    rb_cnt_q, rb_cnt_d;
  logic [3:0]        rb_csum_q, rb_csum_d;
  logic [3:0]        rb_cur;

  assign act_nibs = cell_cfg;
  assign rb_cur   = act_nibs[rb_cnt_q[CW-1:0]];

  // Readback only starts from a quiescent state; a simultaneous cfg_start wins.
  always_comb begin
    rb_act_d  = rb_act_q;
    rb_cnt_d  = rb_cnt_q;
    rb_csum_d = rb_csum_q;
    if (rb_act_q) begin
      if (rb_cnt_q == RB_LAST) begin
        rb_act_d = 1'b0;
      end else begin
        rb_csum_d = rb_csum_q ^ rb_cur;
        rb_cnt_d  = rb_cnt_q + RBW'(1);
      end
    end else if (rb_req && !cfg_start &&
                 (state_q == IDLE || state_q == RUN || state_q == ERR)) begin
      rb_act_d  = 1'b1;
      rb_cnt_d  = '0;
      rb_csum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rb_act_q  <= 1'b0;
      rb_cnt_q  <= '0;
      rb_csum_q <= '0;
    end else begin
      rb_act_q  <= rb_act_d;
      rb_cnt_q  <= rb_cnt_d;
      rb_csum_q <= rb_csum_d;
    end
  end

  assign rb_valid = rb_act_q;
  assign rb_nib   = (rb_cnt_q == RB_LAST) ? rb_csum_q : rb_cur;
  assign rb_busy  = rb_act_q;
`else
  assign rb_busy  = 1'b0;
`endif

  assign start_ok = cfg_start && !rb_busy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    hold_d   = hold_q;
    cfg_ok_d = cfg_ok_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    if (start_ok) begin
      state_d = LOAD;
      cnt_d   = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (cfg_valid) begin
            wr_en  = 1'b1;
            csum_d = csum_q ^ cfg_nib;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = CHECK;
          end
        end
        CHECK: begin
          if (cfg_valid) begin
            if (cfg_nib == csum_q) begin
              commit   = 1'b1;
              cfg_ok_d = 1'b1;
              err_d    = 1'b0;
              hold_d   = HOLD_INIT;
              state_d  = FRST;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end
        end
        FRST: begin
          if (hold_q == '0) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q - RCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      hold_q   <= '0;
      cfg_ok_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      hold_q   <= hold_d;
      cfg_ok_q <= cfg_ok_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign fabric_en  = cfg_ok_q && (state_q != FRST);
  assign fabric_rst = !cfg_ok_q || (state_q == FRST);
  assign busy       = (state_q == LOAD) || (state_q == CHECK) || (state_q == FRST) || rb_busy;
  assign done       = done_q;
  assign err        = err_q;

endmodule
